mult_div_unit: RTL and testbench

Parametrised multicycle multiply/divide unit with HI/LO result registers for the multicycle MIPS datapath. It serves mult, multu, div, divu, mfhi/mflo (read HI/LO) and mthi/mtlo (write HI/LO). The unit runs beside the ALU and takes its operands from the A/B registers. The control unit starts an operation, holds in a wait state while `busy` is high, and resumes when `done` pulses.

---
 rtl/mult_div_unit.sv | 151 +++++++++++++++
 tb/tb_mult_div_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multicycle multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide, one bit per cycle on magnitudes; signs are applied in FIX.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_write,
  input  logic             lo_write,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   opnd_reg;
  logic               is_div_reg;
  logic               dz_reg;
  logic               neg_lo_reg;
  logic               neg_hi_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               div_zero_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;

  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   trial;
  logic               fits;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // Multiply: acc holds {partial product, remaining multiplier bits}, shifted right each step.
  assign add_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
  assign mul_next = {add_sum, acc_reg[WIDTH-1:1]};

  // Divide: acc holds {partial remainder, dividend/quotient bits}, shifted left each step.
  // When the trial fits, the true difference is below the divisor, so WIDTH bits suffice.
  assign shifted  = acc_reg[2*WIDTH-1:WIDTH-1];
  assign fits     = shifted >= {1'b0, opnd_reg};
  assign trial    = shifted[WIDTH-1:0] - opnd_reg;
  assign div_next = fits ? {trial, acc_reg[WIDTH-2:0], 1'b1}
                         : {shifted[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};

  assign prod_fix = neg_lo_reg ? -acc_reg : acc_reg;
  assign quot_fix = neg_lo_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  assign rem_fix  = neg_hi_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      opnd_reg     <= '0;
      is_div_reg   <= 1'b0;
      dz_reg       <= 1'b0;
      neg_lo_reg   <= 1'b0;
      neg_hi_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else begin
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (state_reg == IDLE && start) begin
            state_reg  <= RUN;
            busy_reg   <= 1'b1;
            cnt_reg    <= CNT_W'(WIDTH);
            is_div_reg <= op[1];
            dz_reg     <= op[1] & (b == '0);
            neg_lo_reg <= a_neg ^ b_neg;
            neg_hi_reg <= op[1] ? a_neg : (a_neg ^ b_neg);
            acc_reg    <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
            opnd_reg   <= op[1] ? b_mag : a_mag;
          end else begin
            state_reg <= IDLE;
            if (!start) begin
              if (hi_write) hi_reg <= wdata;
              if (lo_write) lo_reg <= wdata;
            end
          end
        end
        RUN: begin
          if (dz_reg) begin
            // Divide by zero skips the iterations and leaves HI/LO untouched.
            state_reg    <= DONE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b1;
            div_zero_reg <= 1'b1;
            cnt_reg      <= '0;
          end else begin
            acc_reg <= is_div_reg ? div_next : mul_next;
            cnt_reg <= cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) state_reg <= FIX;
          end
        end
        FIX: begin
          if (is_div_reg) begin
            hi_reg <= rem_fix;
            lo_reg <= quot_fix;
          end else begin
            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
            lo_reg <= prod_fix[WIDTH-1:0];
          end
          state_reg <= DONE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign div_zero = div_zero_reg;
  assign hi       = hi_reg;
  assign lo       = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit at WIDTH=32 and WIDTH=8.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hi_write = 1'b0;
  logic        lo_write = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  logic        start8 = 1'b0;
  logic [1:0]  op8 = 2'b00;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8, done8, div_zero8;
  logic [7:0]  hi8, lo8;

  int test_cnt = 0;
  int fail_cnt = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_write(hi_write), .lo_write(lo_write), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .hi_write(1'b0), .lo_write(1'b0), .wdata(8'h00),
    .busy(busy8), .done(done8), .div_zero(div_zero8), .hi(hi8), .lo(lo8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    test_cnt++;
    assert (obs === exp)
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation, optionally disturb it mid-run, and wait (bounded) for done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit hazard, input bit lo_wr,
                        output int lat, output int bcyc,
                        output logic [31:0] rh, output logic [31:0] rl,
                        output logic rdz, output logic rbusy);
    start = 1'b1; op = o; a = x; b = y;
    lo_write = lo_wr; wdata = 32'hDEAD_BEEF;
    tick();
    start = 1'b0; lo_write = 1'b0;
    a = $urandom; b = $urandom;
    lat = 1; bcyc = 0;
    while (!done && lat < 100) begin
      if (busy) bcyc++;
      if (hazard && lat == 5) begin
        start = 1'b1; op = 2'b01; a = 32'h7; b = 32'h9;
        hi_write = 1'b1; wdata = 32'h1234;
      end else begin
        start = 1'b0; hi_write = 1'b0;
      end
      tick();
      lat++;
    end
    rh = hi; rl = lo; rdz = div_zero; rbusy = busy;
    start = 1'b0; hi_write = 1'b0;
    $display("[TB] op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0b lat=%0d", o, x, y, rh, rl, rdz, lat);
    tick();
  endtask

  int          lat, bcyc;
  logic [31:0] rh, rl;
  logic        rdz, rbusy;
  bit          saw_done;

  initial begin
    reset = 1'b0;
    tick(); tick(); tick();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_dz", {63'd0, div_zero}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy8", {63'd0, busy8}, 64'd0);
    reset = 1'b1;
    tick();

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, lat, bcyc, rh, rl, rdz, rbusy);
    check("multu_lat", 64'(lat), 64'd34);
    check("multu_busy_cycles", 64'(bcyc), 64'd33);
    check("multu_busy_at_done", {63'd0, rbusy}, 64'd0);
    check("multu_hi", {32'd0, rh}, 64'h0000_0000_FFFF_FFFE);
    check("multu_lo", {32'd0, rl}, 64'h1);
    check("multu_dz", {63'd0, rdz}, 64'd0);
    check("done_one_cycle", {63'd0, done}, 64'd0);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, lat, bcyc, rh, rl, rdz, rbusy);
    check("mult_neg_hi", {32'd0, rh}, 64'h0000_0000_FFFF_FFFF);
    check("mult_neg_lo", {32'd0, rl}, 64'h0000_0000_FFFF_FFEB);

    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, lat, bcyc, rh, rl, rdz, rbusy);
    check("mult_min_hi", {32'd0, rh}, 64'h4000_0000);
    check("mult_min_lo", {32'd0, rl}, 64'h0);

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, lat, bcyc, rh, rl, rdz, rbusy);
    check("div_neg_lo", {32'd0, rl}, 64'h0000_0000_FFFF_FFFD);
    check("div_neg_hi", {32'd0, rh}, 64'h0000_0000_FFFF_FFFF);
    check("div_lat", 64'(lat), 64'd34);

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, lat, bcyc, rh, rl, rdz, rbusy);
    check("div_ovf_lo", {32'd0, rl}, 64'h8000_0000);
    check("div_ovf_hi", {32'd0, rh}, 64'h0);
    check("div_ovf_dz", {63'd0, rdz}, 64'd0);

    // Extra start and mthi while busy must both be ignored.
    run_op(2'b11, 32'd100, 32'd7, 1'b1, 1'b0, lat, bcyc, rh, rl, rdz, rbusy);
    check("divu_hazard_lo", {32'd0, rl}, 64'd14);
    check("divu_hazard_hi", {32'd0, rh}, 64'd2);
    check("divu_hazard_lat", 64'(lat), 64'd34);
    check("divu_idle_after", {63'd0, busy}, 64'd0);

    run_op(2'b11, 32'd5, 32'd0, 1'b0, 1'b0, lat, bcyc, rh, rl, rdz, rbusy);
    check("divz_lat", 64'(lat), 64'd2);
    check("divz_busy_cycles", 64'(bcyc), 64'd1);
    check("divz_flag", {63'd0, rdz}, 64'd1);
    check("divz_hi_kept", {32'd0, rh}, 64'd2);
    check("divz_lo_kept", {32'd0, rl}, 64'd14);
    check("divz_flag_clears", {63'd0, div_zero}, 64'd0);

    hi_write = 1'b1; wdata = 32'h1234;
    tick();
    hi_write = 1'b0;
    $display("[TB] mthi wdata=00001234 -> hi=%h lo=%h", hi, lo);
    check("mthi_hi", {32'd0, hi}, 64'h1234);
    check("mthi_lo_kept", {32'd0, lo}, 64'd14);

    // mtlo in the same cycle as start is dropped; divide-by-zero leaves LO as it was.
    run_op(2'b11, 32'd9, 32'd0, 1'b0, 1'b1, lat, bcyc, rh, rl, rdz, rbusy);
    check("start_vs_mtlo_lo", {32'd0, rl}, 64'd14);
    check("start_vs_mtlo_hi", {32'd0, rh}, 64'h1234);
    check("start_vs_mtlo_dz", {63'd0, rdz}, 64'd1);

    // Reset in cycle 10 of a multiply.
    start = 1'b1; op = 2'b00; a = 32'h0001_2345; b = 32'h0000_0777;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("mid_busy_before_rst", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    $display("[TB] reset mid-mult -> busy=%0b hi=%h lo=%h", busy, hi, lo);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_hi", {32'd0, hi}, 64'd0);
    check("mid_rst_lo", {32'd0, lo}, 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    check("mid_rst_no_done", {63'd0, saw_done}, 64'd0);

    // WIDTH=8 instance.
    start8 = 1'b1; op8 = 2'b01; a8 = 8'hFF; b8 = 8'hFF;
    tick();
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    lat = 1;
    while (!done8 && lat < 50) begin
      tick();
      lat++;
    end
    $display("[TB] w8 multu a=ff b=ff -> hi=%h lo=%h lat=%0d", hi8, lo8, lat);
    check("w8_lat", 64'(lat), 64'd10);
    check("w8_hi", {56'd0, hi8}, 64'hFE);
    check("w8_lo", {56'd0, lo8}, 64'h01);
    check("w8_dz", {63'd0, div_zero8}, 64'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
